// File: rtl/orth_dds.sv
// Quadrature DDS: phase accumulator + offset into a quarter-wave ROM, signed sin/cos out.
// Latency 3 clocks from accumulator/phase to outputs; free-running pipeline, no backpressure.
module orth_dds #(
    parameter int PW = 32,
    parameter int DW = 16,
    parameter int AW = 13
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 en,
    input  logic [PW-1:0]        freq,
    input  logic [PW-1:0]        phase,
    output logic signed [DW-1:0] sin,
    output logic signed [DW-1:0] cos
);
    localparam int  M    = 2 ** (AW - 2);
    localparam int  AMP  = 2 ** (DW - 1) - 1;
    localparam real PI   = 3.14159265358979323846;
    localparam logic [AW-2:0] M_V = (AW-1)'(M);

    // Quarter-wave table Q[0..M]; Q[M] pinned to full scale so rounding noise cannot touch it
    logic [DW-1:0] w_rom [0:M];
    for (genvar k = 0; k <= M; k++) begin : g_rom
        localparam int QK = (k == M) ? AMP :
            $rtoi(real'(AMP) * $sin(2.0 * PI * real'(k) / real'(2 ** AW)) + 0.5);
        assign w_rom[k] = DW'(QK);
    end

    logic [PW-1:0] r_acc;
    logic [AW-1:0] r_p1;
    logic [DW-1:0] r_sin_mag, r_cos_mag;
    logic          r_sin_neg, r_cos_neg;

    logic [1:0]    w_q;
    logic [AW-2:0] w_r, w_mr, w_sin_addr, w_cos_addr;

    assign w_q        = r_p1[AW-1 -: 2];
    assign w_r        = {1'b0, r_p1[AW-3:0]};
    assign w_mr       = M_V - w_r;
    // Cosine reads quadrant q+1: mirror selection flips, sign is q[1]^q[0]
    assign w_sin_addr = w_q[0] ? w_mr : w_r;
    assign w_cos_addr = w_q[0] ? w_r  : w_mr;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_acc     <= '0;
            r_p1      <= '0;
            r_sin_mag <= '0;
            r_cos_mag <= '0;
            r_sin_neg <= 1'b0;
            r_cos_neg <= 1'b0;
            sin       <= '0;
            cos       <= '0;
        end else begin
            if (en) begin
                r_acc <= r_acc + freq;
            end
            // Only the top AW bits of acc+phase index the table; the rest are truncated
            r_p1      <= AW'((r_acc + phase) >> (PW - AW));
            r_sin_mag <= w_rom[w_sin_addr];
            r_cos_mag <= w_rom[w_cos_addr];
            r_sin_neg <= w_q[1];
            r_cos_neg <= w_q[1] ^ w_q[0];
            sin       <= r_sin_neg ? DW'(-r_sin_mag) : r_sin_mag;
            cos       <= r_cos_neg ? DW'(-r_cos_mag) : r_cos_mag;
        end
    end
endmodule

// File: tb/tb_orth_dds.sv
// Scoreboard bench for orth_dds: stimulus pushes the expected sample per edge, a monitor pops and checks.
module tb_orth_dds;
    localparam real PI = 3.14159265358979323846;

    typedef struct {
        logic signed [15:0] s;
        logic signed [15:0] c;
    } exp_t;

    logic               clk = 1'b0;
    logic               reset = 1'b1;
    logic               en = 1'b0;
    logic [31:0]        freq = '0;
    logic [31:0]        phase = '0;
    logic signed [15:0] dut_sin, dut_cos;

    exp_t        exp_q[$];
    logic [31:0] m_acc = '0;
    int          nchk = 0;
    int          nerr = 0;
    int          edges = 0;

    orth_dds #(.PW(32), .DW(16), .AW(13)) dut (
        .clk   (clk),
        .reset (reset),
        .en    (en),
        .freq  (freq),
        .phase (phase),
        .sin   (dut_sin),
        .cos   (dut_cos)
    );

    always #5 clk = ~clk;

    function automatic int rnd(real v);
        if (v >= 0.0) return $rtoi(v + 0.5);
        return -$rtoi(-v + 0.5);
    endfunction

    function automatic logic signed [15:0] ref_sin(logic [12:0] n);
        return 16'(rnd(32767.0 * $sin(2.0 * PI * real'(n) / 8192.0)));
    endfunction

    function automatic logic signed [15:0] ref_cos(logic [12:0] n);
        return 16'(rnd(32767.0 * $cos(2.0 * PI * real'(n) / 8192.0)));
    endfunction

    // One clock: predict what stage 1 captures at this edge, then advance the model
    task automatic step();
        logic [31:0] p;
        exp_t e;
        p   = m_acc + phase;
        e.s = ref_sin(p[31:19]);
        e.c = ref_cos(p[31:19]);
        exp_q.push_back(e);
        if (en) m_acc = m_acc + freq;
        @(posedge clk);
        #1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic do_reset();
        reset = 1'b1;
        exp_q.delete();
        m_acc = '0;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
    endtask

    task automatic check(input string name, input logic signed [15:0] act, input logic signed [15:0] req);
        nchk++;
        if (act !== req) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, req, $time);
        end
    endtask

    always @(posedge clk) begin
        if (reset) edges = 0;
        else if (edges < 3) edges = edges + 1;
    end

    always @(negedge clk) begin
        exp_t e;
        if (reset) begin
            check("reset_sin", dut_sin, 16'sd0);
            check("reset_cos", dut_cos, 16'sd0);
        end else if (edges >= 3) begin
            if (exp_q.size() == 0) begin
                nchk++;
                nerr++;
                $display("FAIL scoreboard_empty: got no expected entry, required one at %0t", $time);
            end else begin
                e = exp_q.pop_front();
                check("sin", dut_sin, e.s);
                check("cos", dut_cos, e.c);
            end
        end
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation still running at %0t, required finish", $time);
        $display("Result: errors=%0d of %0d checks", nerr + 1, nchk + 1);
        $fatal(1, "timeout");
    end

    initial begin
        // Reset held with clock toggling
        do_reset();

        // Quarter step: sin 0,A,0,-A / cos A,0,-A,0
        freq = 32'h4000_0000; phase = '0; en = 1'b1;
        run(14);
        check("quarter_direct_sin", dut_sin, -16'sd32767);
        check("quarter_direct_cos", dut_cos, 16'sd0);

        // Offset only, then negative offset
        do_reset();
        freq = '0; phase = 32'h4000_0000; en = 1'b1;
        run(6);
        check("offset_pos_sin", dut_sin, 16'sd32767);
        check("offset_pos_cos", dut_cos, 16'sd0);
        phase = 32'hC000_0000;
        run(6);
        check("offset_neg_sin", dut_sin, -16'sd32767);
        check("offset_neg_cos", dut_cos, 16'sd0);

        // Fine step: one ROM entry per cycle over a full period
        do_reset();
        freq = 32'h0008_0000; phase = '0; en = 1'b1;
        run(8200);

        // Enable hold
        do_reset();
        freq = 32'd21474836; phase = '0; en = 1'b1;
        run(30);
        en = 1'b0;
        run(20);
        en = 1'b1;
        run(30);

        // Wrap with a large odd increment and changing offsets
        freq = 32'h8000_0001; phase = 32'h1234_5678;
        run(20);
        phase = 32'hFEDC_BA98;
        run(20);

        // Asynchronous reset mid-cycle: outputs clear before the next edge
        #1;
        reset = 1'b1;
        #1;
        check("async_rst_sin", dut_sin, 16'sd0);
        check("async_rst_cos", dut_cos, 16'sd0);
        do_reset();
        freq = 32'h4000_0000; phase = 32'h2000_0000; en = 1'b1;
        run(12);

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end
endmodule
